// File: rtl/tdm_demux_1x16.sv
// Time-division 1-to-16 demultiplexer: rebuilds a 16-bit word from a serial
// slot stream, aligned by a frame-sync strobe, with one-cycle completion pulses.
module tdm_demux_1x16 #(
    parameter int N = 16,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         din_valid,
    input  logic         sync,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    output logic [S-1:0] slot,
    output logic         frame_err
);

    // Input qualifier: din and sync are consumed only on edges where din_valid
    // is high (a "beat"); there is no ready, the block accepts every beat.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [S-1:0] LAST_SLOT = S'(N - 1);

    state_t         state_q, state_d;
    logic [N-2:0]   shadow_q, shadow_d;
    logic [S-1:0]   slot_q, slot_d;
    logic [N-1:0]   dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        slot_d       = slot_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync) begin
                        shadow_d = {{(N-2){1'b0}}, din};
                        slot_d   = S'(1);
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sync && (slot_q != '0)) begin
                        // Early sync: drop the partial frame and restart at slot 0.
                        frame_err_d = 1'b1;
                        shadow_d    = {{(N-2){1'b0}}, din};
                        slot_d      = S'(1);
                    end else if (slot_q == LAST_SLOT) begin
                        dout_d       = {din, shadow_q};
                        dout_valid_d = 1'b1;
                        slot_d       = '0;
                    end else begin
                        shadow_d[slot_q] = din;
                        slot_d           = slot_q + S'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            slot_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_1x16.sv
// Directed bench for tdm_demux_1x16: hand-computed words sent LSB-first
// (slot k carries bit k), checked with immediate assertions at each step.
module tb_tdm_demux_1x16;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        sync;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  slot;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_a, pulse_b;

    logic [15:0] exp_q[$];

    tdm_demux_1x16 #(.N(16), .S(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .frame_err  (frame_err)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs at the falling edge, observe #1 after the rising edge.
    task automatic step(input logic v, input logic s, input logic d);
        @(negedge clk);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    // Model of the 16x1 mux that feeds this block.
    function automatic logic mux16(input logic [15:0] i, input logic [3:0] s);
        return i[s];
    endfunction

    // Full 16-beat frame starting at slot 0; gap inserts an idle edge before each beat.
    task automatic send_frame(input logic [15:0] word, input logic first_sync,
                              input logic exp_err, input logic gap);
        logic [15:0] prev;
        prev = dout;
        for (int k = 0; k < 16; k++) begin
            if (gap) begin
                step(1'b0, 1'b1, 1'b1);
                check("gap_no_valid", {15'b0, dout_valid}, 16'h0);
            end
            step(1'b1, first_sync && (k == 0), mux16(word, 4'(k)));
            check("slot_adv", {12'b0, slot}, 16'((k + 1) % 16));
            check("err", {15'b0, frame_err}, {15'b0, exp_err && (k == 0)});
            if (k < 15) begin
                check("no_valid_mid", {15'b0, dout_valid}, 16'h0);
                check("dout_hold", dout, prev);
            end
        end
        exp_q.push_back(word);
        check("valid_pulse", {15'b0, dout_valid}, 16'h1);
        check("dout_word", dout, exp_q.pop_front());
        pulse_b = pulse_a;
        pulse_a = cyc;
    endtask

    task automatic partial(input logic [15:0] word, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, k == 0, word[k]);
            check("part_slot", {12'b0, slot}, 16'(k + 1));
            check("part_no_valid", {15'b0, dout_valid}, 16'h0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, dout, 16'h0);
        check({tag, "_valid"}, {15'b0, dout_valid}, 16'h0);
        check({tag, "_slot"}, {12'b0, slot}, 16'h0);
        check({tag, "_err"}, {15'b0, frame_err}, 16'h0);
    endtask

    initial begin
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
        pulse_a = 0; pulse_b = 0;

        // Reset asserted between edges takes effect without a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;

        // Beats without sync in IDLE are ignored.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, k[0]);
            check("idle_slot", {12'b0, slot}, 16'h0);
            check("idle_no_valid", {15'b0, dout_valid}, 16'h0);
        end
        step(1'b0, 1'b1, 1'b1);
        check("idle_sync_unqual", {12'b0, slot}, 16'h0);

        // Single frame.
        send_frame(16'hA5C3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("pulse_one_cycle", {15'b0, dout_valid}, 16'h0);
        check("dout_held", dout, 16'hA5C3);

        // Round trip, two back-to-back frames with one initial sync.
        send_frame(16'h1234, 1'b1, 1'b0, 1'b0);
        send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
        check("b2b_spacing", 16'(pulse_a - pulse_b), 16'd16);

        // Gapped input; the redundant sync at slot 0 raises no error.
        send_frame(16'h8001, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("gap_pulse_once", {15'b0, dout_valid}, 16'h0);

        // Early sync after 7 beats.
        partial(16'h0000, 7);
        send_frame(16'hFFFF, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("after_err_err", {15'b0, frame_err}, 16'h0);
        check("after_err_dout", dout, 16'hFFFF);

        // Reset mid-frame after 9 beats.
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        partial(16'hFFFF, 0);
        for (int k = 0; k < 9; k++) step(1'b1, k == 0, 1'b1);
        check("pre_rst_slot", {12'b0, slot}, 16'd9);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid2");
        @(negedge clk);
        rst = 1'b0;
        send_frame(16'h00FF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("final_dout", dout, 16'h00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x16.md
# tdm_demux_1x16

Time-division 1-to-16 demultiplexer: it receives a serial bit stream one slot per valid cycle and steers slot k into bit k of a 16-bit parallel word. It is the receive end of the 16x1 mux: a mux whose select counts 0..15 drives this block, and this block rebuilds the original `i[15:0]`. An internal 4-bit slot counter replaces the external select and is aligned by a frame-sync strobe. Each completed word is presented with a one-cycle valid pulse.

## Interface
Parameters:
- `N`, 16: number of output lanes (slots per frame). Only 16 is supported.
- `S`, 4: slot counter width, log2(N).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  1  serial data for the current slot.
- `din_valid`  in  1  `din` is sampled on this edge only when high.
- `sync`  in  1  frame start; qualified by `din_valid`; marks the current `din` as slot 0.
- `dout`  out  16  last completed word; bit k holds the bit received in slot k.
- `dout_valid`  out  1  one-cycle pulse when `dout` updates.
- `slot`  out  4  next slot index to be filled (equivalent to mux `s`).
- `frame_err`  out  1  one-cycle pulse when a frame is aborted by an early sync.

## Operation
- State machine has two states:
  - IDLE: waiting for alignment.
  - RUN: aligned, filling slots.
- Internal registers:
  - `shadow[14:0]` holds the partial frame.
  - `slot` is the 4-bit counter.
- Beat definitions:
  - A beat is a clock edge with `din_valid`=1.
  - Edges with `din_valid`=0 change nothing, and all pulses deassert.
- In IDLE:
  - A beat with `sync`=0 is ignored, and `slot` stays 0.
  - A beat with `sync`=1 sets `shadow[0]`=`din` and `slot`=1, and the block enters RUN.
- In RUN, a beat with `sync`=0 at `slot`=k<15 sets `shadow[k]`=`din` and `slot`=k+1.
- In RUN, a beat with `sync`=0 at `slot`=15 (frame complete):
  - `dout` becomes {`din`, `shadow[14:0]`} and `dout_valid` becomes 1.
  - `slot` wraps to 0 and the block stays in RUN, so back-to-back frames need no new sync.
- In RUN, a beat with `sync`=1 at `slot`=0 is a normal slot-0 capture (sync is redundant), and `frame_err` stays 0.
- In RUN, a beat with `sync`=1 at `slot`≠0 (early sync):
  - `frame_err` pulses 1 and the partial frame is discarded.
  - `dout` and `dout_valid` are unchanged, and `dout_valid` is 0 on that edge.
  - The current `din` goes to `shadow[0]` and `slot` becomes 1.
- `sync` with `din_valid`=0 is ignored.
- `dout` holds its value until the next completed frame. There is no backpressure: the consumer must take the word during the `dout_valid` cycle.

## Timing
- Reset values:
  - `dout`=16'h0000, `dout_valid`=0, `frame_err`=0, `slot`=0, state IDLE, `shadow`=0.
  - Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-frame drops the partial frame. After reset the block needs a new sync.
- `slot` is a registered output that shows the index the next beat will write.
- Latency:
  - `dout` and `dout_valid` are registered.
  - They become visible after the edge that samples slot 15, i.e. 16 beats after the sync beat when there are no gaps.
- `dout_valid` is high for exactly one cycle per completed frame. With continuous beats the pulses are 16 cycles apart.
- `frame_err` is registered and high for exactly one cycle, on the edge after the offending beat.
- `dout_valid` and `frame_err` are never high in the same cycle.
- Gaps in `din_valid` stretch the frame without limit. There is no timeout.

## Test plan
- Reset: assert `rst` between edges -> all outputs 0 immediately. Release, then drive beats with `sync`=0 -> `slot` stays 0 and `dout_valid` never pulses.
- Single frame: `sync` on the first beat, then 16 continuous beats carrying bits of 16'hA5C3 LSB-first (slot k = bit k) -> `dout`=16'hA5C3 and `dout_valid`=1 for one cycle, one cycle after the 16th beat, with `slot`=0.
- Round trip and back-to-back: drive `din` from a 16x1 mux with `i`=16'h1234 and `s` stepped 0..15, for two frames with a single initial sync -> `dout`=16'h1234 twice, with `dout_valid` pulses 16 cycles apart.
- Gapped input: 16'h8001 with `din_valid` low on every other cycle -> `dout`=16'h8001. `dout_valid` pulses once, after the 16th valid beat (edge 32).
- Early sync: after 7 beats of a frame, assert `sync` and then send a full 16'hFFFF frame -> `frame_err` pulses once. `dout` updates only to 16'hFFFF, and there is no `dout_valid` for the aborted frame.
- Reset mid-frame: reset after 9 beats, then send 16'h00FF with sync -> `dout`=16'h00FF with no leftover bits.
